// File: rtl/pid_pkg.sv
// Shared widths, limits and the signed saturation helper for the drive current PID loop.
package pid_pkg;

  localparam int ERR_W     = 10;
  localparam int INTEG_W   = 18;
  localparam logic [INTEG_W-1:0] INTEG_MAX = 18'h1FFFF;
  localparam int PID_W     = 14;
  localparam int D_SAT_W   = 9;
  localparam int CURR_W    = 12;
  localparam logic [CURR_W-1:0] DRV_MAX = 12'hFFF;

  // Clamp a signed value into the range representable by a w-bit signed number.
  function automatic logic signed [31:0] sat_to_signed(input logic signed [31:0] v,
                                                       input int unsigned w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/pid_err_hist.sv
// Error history shift register; err_old is the sample taken D_DEPTH ticks ago.
module pid_err_hist
  import pid_pkg::*;
#(
  parameter int D_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic signed [ERR_W-1:0] err_in,
  output logic signed [ERR_W-1:0] err_old
);

  logic signed [ERR_W-1:0] hist [D_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < D_DEPTH; k++) begin
        hist[k] <= '0;
      end
    end else if (tick) begin
      hist[0] <= err_in;
      for (int k = 1; k < D_DEPTH; k++) begin
        hist[k] <= hist[k-1];
      end
    end
  end

  assign err_old = hist[D_DEPTH-1];

endmodule

// File: rtl/drive_pid.sv
// Motor current PID: P every clock, I and D on a decimated tick; drv_mag registered, 1 clock latency.
module drive_pid
  import pid_pkg::*;
#(
  parameter int DEC_W   = 20,
  parameter int D_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CURR_W-1:0] target_curr,
  input  logic [CURR_W-1:0] avg_curr,
  input  logic              not_pedaling,
  output logic [CURR_W-1:0] drv_mag
);

  logic [DEC_W-1:0]         dec_cnt;
  logic                     tick;
  logic signed [CURR_W:0]   err;
  logic signed [ERR_W-1:0]  err_sat;
  logic signed [ERR_W-1:0]  err_old;
  logic signed [ERR_W:0]    d_diff;
  logic signed [D_SAT_W-1:0] d_sat;
  logic signed [PID_W-1:0]  p_term;
  logic signed [PID_W-1:0]  i_term;
  logic signed [PID_W-1:0]  d_term;
  logic signed [PID_W-1:0]  pid;
  logic [INTEG_W-1:0]       integ;
  logic signed [INTEG_W:0]  integ_sum;
  logic [INTEG_W-1:0]       integ_next;
  logic [CURR_W-1:0]        drv_next;

  assign tick = &dec_cnt;

  assign err     = $signed({1'b0, target_curr}) - $signed({1'b0, avg_curr});
  assign err_sat = ERR_W'(sat_to_signed(32'(err), ERR_W));

  pid_err_hist #(
    .D_DEPTH (D_DEPTH)
  ) u_err_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .err_in  (err_sat),
    .err_old (err_old)
  );

  // Differences up to +-1023 need one extra bit before the 9-bit clamp.
  assign d_diff = {err_sat[ERR_W-1], err_sat} - {err_old[ERR_W-1], err_old};
  assign d_sat  = D_SAT_W'(sat_to_signed(32'(d_diff), D_SAT_W));

  assign p_term = {{(PID_W-ERR_W){err_sat[ERR_W-1]}}, err_sat};
  assign i_term = {2'b00, integ[16:5]};
  assign d_term = {{(PID_W-D_SAT_W-1){d_sat[D_SAT_W-1]}}, d_sat, 1'b0};
  assign pid    = p_term + i_term + d_term;

  // integ is never negative, so zero-extending it keeps the sum exact in 19 bits.
  assign integ_sum = {1'b0, integ} + {{(INTEG_W+1-ERR_W){err_sat[ERR_W-1]}}, err_sat};

  always_comb begin
    integ_next = integ_sum[INTEG_W-1:0];
    if (integ_sum[INTEG_W]) begin
      integ_next = '0;
    end else if (integ_sum[INTEG_W-1]) begin
      integ_next = INTEG_MAX;
    end
  end

  always_comb begin
    drv_next = pid[CURR_W-1:0];
    if (pid < 14'sd0) begin
      drv_next = '0;
    end else if (pid > 14'sd4095) begin
      drv_next = DRV_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_cnt <= '0;
      integ   <= '0;
      drv_mag <= '0;
    end else begin
      dec_cnt <= dec_cnt + DEC_W'(1);
      if (not_pedaling) begin
        integ   <= '0;
        drv_mag <= '0;
      end else begin
        drv_mag <= drv_next;
        if (tick) begin
          integ <= integ_next;
        end
      end
    end
  end

endmodule
